// File: rtl/mc_reg_bridge_if.sv
// MCU parallel memory-controller bus as seen by the register bridge.
interface mc_reg_bridge_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADD_WIDTH  = 6
);
    logic                  mc_ce_n;
    logic                  mc_we_n;
    logic                  mc_oe_n;
    logic [ADD_WIDTH-1:0]  mc_add;
    logic [DATA_WIDTH-1:0] mc_din;
    logic [DATA_WIDTH-1:0] mc_dout;
    logic                  mc_dout_oe;

    modport master (
        output mc_ce_n, mc_we_n, mc_oe_n, mc_add, mc_din,
        input  mc_dout, mc_dout_oe
    );

    modport slave (
        input  mc_ce_n, mc_we_n, mc_oe_n, mc_add, mc_din,
        output mc_dout, mc_dout_oe
    );
endinterface

// File: rtl/mc_reg_bridge.sv
// Register bridge: MCU async parallel bus -> PWM / pin-buffer control registers.
// Optional pin-change interrupt logic is built when BP_MC_IRQ_EN is defined.
module mc_reg_bridge #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADD_WIDTH   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst,
    mc_reg_bridge_if.slave    bus,
    output logic              pwm_reset,
    output logic [15:0]       pwm_onperiod,
    output logic [15:0]       pwm_offperiod,
    output logic [4:0]        buf_oe,
    output logic [4:0]        buf_od,
    output logic [4:0]        buf_dir,
    output logic [4:0]        buf_dout,
    input  logic [4:0]        buf_din,
    output logic              irq0_out,
    output logic              irq0_dir
);

    localparam logic [ADD_WIDTH-1:0] A_ID       = ADD_WIDTH'(6'h00);
    localparam logic [ADD_WIDTH-1:0] A_CTRL     = ADD_WIDTH'(6'h01);
    localparam logic [ADD_WIDTH-1:0] A_PWM_ON   = ADD_WIDTH'(6'h02);
    localparam logic [ADD_WIDTH-1:0] A_PWM_OFF  = ADD_WIDTH'(6'h03);
    localparam logic [ADD_WIDTH-1:0] A_BUF_OE   = ADD_WIDTH'(6'h04);
    localparam logic [ADD_WIDTH-1:0] A_BUF_OD   = ADD_WIDTH'(6'h05);
    localparam logic [ADD_WIDTH-1:0] A_BUF_DIR  = ADD_WIDTH'(6'h06);
    localparam logic [ADD_WIDTH-1:0] A_BUF_DOUT = ADD_WIDTH'(6'h07);
    localparam logic [ADD_WIDTH-1:0] A_BUF_DIN  = ADD_WIDTH'(6'h08);
    localparam logic [ADD_WIDTH-1:0] A_SCRATCH  = ADD_WIDTH'(6'h0B);
`ifdef BP_MC_IRQ_EN
    localparam logic [ADD_WIDTH-1:0] A_IRQ_STAT = ADD_WIDTH'(6'h09);
    localparam logic [ADD_WIDTH-1:0] A_IRQ_MASK = ADD_WIDTH'(6'h0A);
`endif
    localparam logic [15:0] ID_VALUE = 16'h5042;

    logic [SYNC_STAGES-1:0]      ce_sync, we_sync, oe_sync, sync_vld;
    logic [SYNC_STAGES-1:0][4:0] din_sync;
    logic [4:0]                  din_s;
    logic                        wr, rd, wr_d, armed, wr_commit;
    logic                        irq_en;
    logic [15:0]                 scratch, wdata, rdata;

    assign din_s = din_sync[SYNC_STAGES-1];
    assign wr    = ~ce_sync[SYNC_STAGES-1] & ~we_sync[SYNC_STAGES-1];
    assign rd    = ~ce_sync[SYNC_STAGES-1] & ~oe_sync[SYNC_STAGES-1] & we_sync[SYNC_STAGES-1];
    assign wdata = 16'(bus.mc_din);

    // Strobe and pin synchronizers; sync_vld marks when the last stage holds a real sample.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ce_sync  <= '1;
            we_sync  <= '1;
            oe_sync  <= '1;
            din_sync <= '0;
            sync_vld <= '0;
        end else begin
            ce_sync  <= {ce_sync[SYNC_STAGES-2:0], bus.mc_ce_n};
            we_sync  <= {we_sync[SYNC_STAGES-2:0], bus.mc_we_n};
            oe_sync  <= {oe_sync[SYNC_STAGES-2:0], bus.mc_oe_n};
            din_sync <= {din_sync[SYNC_STAGES-2:0], buf_din};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Write edge detect, armed only after a genuine idle strobe has been seen.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_d      <= 1'b0;
            armed     <= 1'b0;
            wr_commit <= 1'b0;
        end else begin
            wr_d      <= wr;
            armed     <= armed | (sync_vld[SYNC_STAGES-1] & ~wr);
            wr_commit <= wr & ~wr_d & armed;
        end
    end

    // Control registers, written on the commit cycle.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pwm_reset     <= 1'b1;
            irq_en        <= 1'b0;
            pwm_onperiod  <= 16'h0002;
            pwm_offperiod <= 16'h0081;
            buf_oe        <= '0;
            buf_od        <= '0;
            buf_dir       <= '0;
            buf_dout      <= '0;
            scratch       <= '0;
        end else if (wr_commit) begin
            case (bus.mc_add)
                A_CTRL: begin
                    pwm_reset <= wdata[0];
                    irq_en    <= wdata[1];
                end
                A_PWM_ON:   pwm_onperiod  <= wdata;
                A_PWM_OFF:  pwm_offperiod <= wdata;
                A_BUF_OE:   buf_oe        <= wdata[4:0];
                A_BUF_OD:   buf_od        <= wdata[4:0];
                A_BUF_DIR:  buf_dir       <= wdata[4:0];
                A_BUF_DOUT: buf_dout      <= wdata[4:0];
                A_SCRATCH:  scratch       <= wdata;
                default: ;
            endcase
        end
    end

`ifdef BP_MC_IRQ_EN
    logic [4:0] irq_status, irq_mask, din_d, din_rise, irq_clr;

    assign din_rise = din_s & ~din_d;
    assign irq_clr  = (wr_commit && bus.mc_add == A_IRQ_STAT) ? wdata[4:0] : 5'd0;

    // Pin-change status (set beats W1C), mask, and registered irq pad outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            din_d      <= '0;
            irq_status <= '0;
            irq_mask   <= '0;
            irq0_out   <= 1'b0;
            irq0_dir   <= 1'b0;
        end else begin
            din_d      <= din_s;
            irq_status <= (irq_status & ~irq_clr) | (din_rise & irq_mask);
            if (wr_commit && bus.mc_add == A_IRQ_MASK)
                irq_mask <= wdata[4:0];
            irq0_out   <= irq_en & |(irq_status & irq_mask);
            irq0_dir   <= irq_en;
        end
    end
`else
    assign irq0_out = 1'b0;
    assign irq0_dir = 1'b0;
`endif

    // Read mux; unused bits and unmapped addresses read zero.
    always_comb begin
        rdata = '0;
        case (bus.mc_add)
            A_ID:       rdata = ID_VALUE;
            A_CTRL:     rdata = {14'd0, irq_en, pwm_reset};
            A_PWM_ON:   rdata = pwm_onperiod;
            A_PWM_OFF:  rdata = pwm_offperiod;
            A_BUF_OE:   rdata = {11'd0, buf_oe};
            A_BUF_OD:   rdata = {11'd0, buf_od};
            A_BUF_DIR:  rdata = {11'd0, buf_dir};
            A_BUF_DOUT: rdata = {11'd0, buf_dout};
            A_BUF_DIN:  rdata = {11'd0, din_s};
`ifdef BP_MC_IRQ_EN
            A_IRQ_STAT: rdata = {11'd0, irq_status};
            A_IRQ_MASK: rdata = {11'd0, irq_mask};
`endif
            A_SCRATCH:  rdata = scratch;
            default:    rdata = '0;
        endcase
    end

    // Registered read data and pad drive enable.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bus.mc_dout    <= '0;
            bus.mc_dout_oe <= 1'b0;
        end else begin
            bus.mc_dout    <= rd ? DATA_WIDTH'(rdata) : '0;
            bus.mc_dout_oe <= rd;
        end
    end

endmodule
